// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the uart_tx arbiter: the sequencing FSM state
// encoding and the window, in cycles, that the arbiter waits for the
// serializer to raise busy after a start pulse.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_e;

    // Cycles spent in WAIT_HI without seeing busy before the byte is
    // treated as already sent.
    localparam int WAIT_HI_TIMEOUT = 2;
    localparam int TO_CNT_W        = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. The search starts one position after
// i_ptr, wraps modulo NREQ, and grants the first eligible index.
//
// Ports:
//   i_elig   [NREQ-1:0]  eligible requesters
//   i_ptr    [IDW-1:0]   index of the previous winner
//   o_grant  [NREQ-1:0]  one-hot grant, zero when nothing is eligible
//   o_idx    [IDW-1:0]   binary index of the granted requester
//   o_any                at least one requester is eligible
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        logic found;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        // Walk offsets 1..NREQ from the pointer; offset NREQ lands back on
        // the previous winner, so it wins again only if it is alone.
        for (int off = 1; off <= NREQ; off++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && i_elig[j] && (j == (int'(i_ptr) + off) % NREQ)) begin
                    found      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDW'(j);
                end
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx serializer between NREQ byte producers with
// round-robin fairness and a packet lock that keeps a multi-byte message
// from being interleaved with other requesters.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid [NREQ-1:0]     requester i offers a byte
//   req_data  [8*NREQ-1:0]   byte of requester i at [8i+7:8i]
//   req_last  [NREQ-1:0]     byte is the final one of its packet
//   req_ready [NREQ-1:0]     one-hot accept, combinational in IDLE
//   tx_data   [7:0]          byte presented to uart_tx
//   tx_start                 one-cycle start pulse to uart_tx
//   tx_busy                  busy flag from uart_tx
//   grant_id  [IDW-1:0]      index of the last accepted requester
//   locked                   a packet is in progress
//   dbg_state                current sequencing FSM state
//
// Handshake: a byte moves from requester i on a rising edge where
// req_valid[i] and req_ready[i] are both high. A requester holds req_data
// and req_last stable while req_valid is high and not yet accepted; the
// arbiter only raises req_ready while IDLE, out of reset, with tx_busy low.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              locked,
    output arb_state_e        dbg_state
);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [7:0]            r_tx_data;
    logic [IDW-1:0]        r_grant_id;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_owner;
    logic                  r_locked;
    logic [TO_CNT_W-1:0]   r_to_cnt;

    logic [NREQ-1:0]       w_owner_mask;
    logic [NREQ-1:0]       w_elig;
    logic [NREQ-1:0]       w_grant;
    logic [IDW-1:0]        w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic [7:0]            w_sel_data;
    logic                  w_sel_last;
    logic                  w_tx_start;

    // While a packet is open only its owner may compete.
    assign w_owner_mask = NREQ'(1) << r_owner;
    assign w_elig       = r_locked ? (req_valid & w_owner_mask) : req_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Gating with rst keeps a reset cycle from looking like a transfer to
    // the requester, since the registers below will not capture it.
    assign w_accept  = (r_state == IDLE) && !rst && !tx_busy && w_any;
    assign req_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_sel_data = 8'h00;
        w_sel_last = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant[j]) begin
                w_sel_data = req_data[8*j +: 8];
                w_sel_last = req_last[j];
            end
        end
    end

    // Next-state and outputs. tx_start depends on state only, so there is
    // no combinational path from tx_busy to it.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx_start  = 1'b1;
                w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_to_cnt == TO_CNT_W'(WAIT_HI_TIMEOUT - 1)) begin
                    // Serializer finished already or missed the pulse.
                    w_state_nxt = IDLE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_data  <= 8'h00;
            r_grant_id <= '0;
            r_rr_ptr   <= IDW'(NREQ - 1);
            r_owner    <= '0;
            r_locked   <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == WAIT_HI) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_accept) begin
                r_tx_data  <= w_sel_data;
                r_grant_id <= w_idx;
                r_rr_ptr   <= w_idx;
                r_owner    <= w_idx;
                r_locked   <= !w_sel_last;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_start  = w_tx_start;
    assign grant_id  = r_grant_id;
    assign locked    = r_locked;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with NREQ=4: directed scenarios plus random
// packet traffic, checked by a negedge monitor against a reference model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_last  = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic [IDW-1:0]    grant_id;
    logic              locked;
    arb_state_e        dbg_state;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .locked    (locked),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester drivers ----------------
    logic [8:0]      src_mem [NREQ][256];
    int              src_head [NREQ] = '{default: 0};
    int              src_tail [NREQ] = '{default: 0};
    bit              src_on   [NREQ] = '{default: 0};
    int              raise_pct = 100;
    logic [NREQ-1:0] acc_mask = '0;

    task automatic push_byte(input int r, input logic [7:0] d, input bit last);
        src_mem[r][src_tail[r] % 256] = {last, d};
        src_tail[r]++;
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NREQ; i++) if (src_head[i] != src_tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
                src_head[i]++;
                src_on[i] = 1'b0;
            end
            if (!src_on[i] && src_head[i] < src_tail[i] && int'($urandom_range(0, 99)) < raise_pct)
                src_on[i] = 1'b1;
            req_valid[i] = src_on[i];
            req_data[8*i +: 8] = src_on[i] ? src_mem[i][src_head[i] % 256][7:0] : 8'($urandom);
            req_last[i] = src_on[i] ? src_mem[i][src_head[i] % 256][8] : 1'($urandom);
        end
        acc_mask = '0;
    end

    // ---------------- uart_tx model ----------------
    int busy_cnt   = 0;
    bit never_busy = 1'b0;
    bit rand_busy  = 1'b0;
    int busy_len   = 20;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (tx_start && !never_busy) busy_cnt = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
        end
        tx_busy = (busy_cnt > 0);
    end

    // ---------------- reference model + scoreboard ----------------
    int             m_ptr = NREQ - 1;
    bit             m_locked = 1'b0;
    int             m_owner = 0;
    logic [7:0]     exp_q[$];
    logic [IDW-1:0] exp_id_q[$];
    bit             acc_prev = 1'b0;
    int             gap = 100;
    logic [7:0]     hold;
    bit             hold_valid = 1'b0;
    logic [7:0]     log_q[$];
    logic [IDW-1:0] log_id[$];
    int             gap_log[$];

    // Winner = eligible index at the smallest circular distance after ptr.
    function automatic int rr_expect(input logic [NREQ-1:0] v, input int ptr);
        int best = -1;
        int bd   = NREQ;
        int d;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                d = (i - ptr - 1 + 2 * NREQ) % NREQ;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin : monitor
        int w;
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] exp_gnt;
        logic [7:0] eb;
        logic [IDW-1:0] ei;
        if (rst) begin
            chk(req_ready == '0, "ready_in_reset", 32'(req_ready), 0);
            m_ptr = NREQ - 1; m_locked = 1'b0; m_owner = 0;
            exp_q.delete(); exp_id_q.delete();
            acc_prev = 1'b0; hold_valid = 1'b0; gap = 100; acc_mask = '0;
        end else begin
            if (tx_start || acc_prev)
                chk(tx_start == acc_prev, "start_latency", 32'(tx_start), 32'(acc_prev));
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "start_unexpected", 32'(tx_data), 0);
                end else begin
                    eb = exp_q.pop_front();
                    ei = exp_id_q.pop_front();
                    chk(tx_data == eb, "tx_data", 32'(tx_data), 32'(eb));
                    chk(grant_id == ei, "grant_id", 32'(grant_id), 32'(ei));
                end
                log_q.push_back(tx_data);
                log_id.push_back(grant_id);
                hold = tx_data;
                hold_valid = 1'b1;
            end else if (hold_valid) begin
                chk(tx_data == hold, "data_hold", 32'(tx_data), 32'(hold));
            end
            chk(locked == m_locked, "locked", 32'(locked), 32'(m_locked));
            gap++;
            elig = m_locked ? (req_valid & (NREQ'(1) << m_owner)) : req_valid;
            w = rr_expect(elig, m_ptr);
            exp_gnt = '0;
            if (w >= 0) exp_gnt[w] = 1'b1;
            acc_prev = 1'b0;
            acc_mask = '0;
            if (req_ready != '0) begin
                chk(req_ready == exp_gnt, "grant", 32'(req_ready), 32'(exp_gnt));
                chk(!tx_busy, "ready_while_busy", 32'(tx_busy), 0);
                chk(gap >= 3, "accept_spacing", 32'(gap), 3);
                gap_log.push_back(gap);
                if (w >= 0) begin
                    exp_q.push_back(src_mem[w][src_head[w] % 256][7:0]);
                    exp_id_q.push_back(IDW'(w));
                    m_ptr = w;
                    if (src_mem[w][src_head[w] % 256][8]) begin
                        m_locked = 1'b0;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = w;
                    end
                end
                acc_prev = 1'b1;
                gap = 0;
                acc_mask = req_ready & req_valid;
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [7:0]     dir_b[$];
    logic [IDW-1:0] dir_i[$];

    task automatic clear_log();
        log_q.delete(); log_id.delete(); gap_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (n < 3000 && !(src_empty() && exp_q.size() == 0 && !tx_busy && dbg_state == IDLE)) begin
            @(posedge clk);
            n++;
        end
        chk(n < 3000, name, 32'(n), 3000);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_log(input string name);
        chk(log_q.size() == dir_b.size(), {name, "_count"}, 32'(log_q.size()), 32'(dir_b.size()));
        for (int i = 0; i < dir_b.size() && i < log_q.size(); i++) begin
            chk(log_q[i] == dir_b[i], {name, "_byte"}, 32'(log_q[i]), 32'(dir_b[i]));
            chk(log_id[i] == dir_i[i], {name, "_id"}, 32'(log_id[i]), 32'(dir_i[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int r;
        int len;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk(tx_start == 1'b0, "rst_tx_start", 32'(tx_start), 0);
        chk(tx_data == 8'h00, "rst_tx_data", 32'(tx_data), 0);
        chk(req_ready == '0, "rst_req_ready", 32'(req_ready), 0);
        chk(grant_id == '0, "rst_grant_id", 32'(grant_id), 0);
        chk(locked == 1'b0, "rst_locked", 32'(locked), 0);
        chk(dbg_state == IDLE, "rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1 rst = 1'b0;

        // Single byte
        clear_log();
        push_byte(0, 8'h41, 1'b1);
        wait_drain("drain_single");
        dir_b = {8'h41}; dir_i = {2'd0};
        chk_log("single");

        // Fair contention
        do_reset(); clear_log();
        push_byte(0, 8'hA0, 1'b1); push_byte(1, 8'hB0, 1'b1);
        push_byte(0, 8'hA0, 1'b1); push_byte(1, 8'hB0, 1'b1);
        wait_drain("drain_fair");
        dir_b = {8'hA0, 8'hB0, 8'hA0, 8'hB0}; dir_i = {2'd0, 2'd1, 2'd0, 2'd1};
        chk_log("fair");

        // Packet lock
        do_reset(); clear_log();
        push_byte(1, 8'h10, 1'b0); push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h12, 1'b1);
        n = 0;
        while (n < 200 && !locked) begin @(negedge clk); n++; end
        chk(n < 200, "lock_wait", 32'(n), 200);
        push_byte(0, 8'h55, 1'b1);
        wait_drain("drain_lock");
        dir_b = {8'h10, 8'h11, 8'h12, 8'h55}; dir_i = {2'd1, 2'd1, 2'd1, 2'd0};
        chk_log("lock");

        // Missed busy: serializer never raises busy
        never_busy = 1'b1; clear_log();
        for (int i = 0; i < 3; i++) push_byte(0, 8'($urandom), 1'b1);
        for (int i = 0; i < 2; i++) push_byte(2, 8'($urandom), 1'b1);
        wait_drain("drain_missed");
        chk(log_q.size() == 5, "missed_starts", 32'(log_q.size()), 5);
        chk(gap_log.size() == 5, "missed_accepts", 32'(gap_log.size()), 5);
        for (int i = 1; i < gap_log.size(); i++)
            chk(gap_log[i] == 4, "missed_gap", 32'(gap_log[i]), 4);
        never_busy = 1'b0;

        // Reset mid-packet during WAIT_LO
        busy_len = 20;
        do_reset(); clear_log();
        push_byte(1, 8'h21, 1'b0); push_byte(1, 8'h22, 1'b0); push_byte(1, 8'h23, 1'b1);
        n = 0;
        while (n < 200 && !(locked && dbg_state == WAIT_LO)) begin @(negedge clk); n++; end
        chk(n < 200, "wlo_wait", 32'(n), 200);
        @(posedge clk); #1 rst = 1'b1;
        push_byte(0, 8'h77, 1'b1);
        clear_log();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk(tx_start == 1'b0, "mid_rst_tx_start", 32'(tx_start), 0);
        chk(tx_data == 8'h00, "mid_rst_tx_data", 32'(tx_data), 0);
        chk(grant_id == '0, "mid_rst_grant_id", 32'(grant_id), 0);
        chk(locked == 1'b0, "mid_rst_locked", 32'(locked), 0);
        chk(dbg_state == IDLE, "mid_rst_state", 32'(dbg_state), 32'(IDLE));
        wait_drain("drain_midrst");
        dir_b = {8'h77, 8'h22, 8'h23}; dir_i = {2'd0, 2'd1, 2'd1};
        chk_log("midrst");

        // Random packet traffic
        do_reset(); clear_log();
        raise_pct = 60; rand_busy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            r   = int'($urandom_range(0, NREQ - 1));
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
        end
        wait_drain("drain_random");
        raise_pct = 100; rand_busy = 1'b0;

        // Wrap-around with requesters 1 and 3
        do_reset(); clear_log();
        push_byte(1, 8'h31, 1'b1); push_byte(3, 8'h33, 1'b1);
        push_byte(1, 8'h32, 1'b1); push_byte(3, 8'h34, 1'b1);
        wait_drain("drain_wrap");
        dir_b = {8'h31, 8'h33, 8'h32, 8'h34}; dir_i = {2'd1, 2'd3, 2'd1, 2'd3};
        chk_log("wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
